// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard direction scheduler: scan codes,
// one-hot direction encoding, command format and scheduler FSM states.
package kbd_pkg;

    localparam logic [8:0] SC_UP    = 9'h01D;
    localparam logic [8:0] SC_DOWN  = 9'h01B;
    localparam logic [8:0] SC_LEFT  = 9'h01C;
    localparam logic [8:0] SC_RIGHT = 9'h023;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic       rpt;
        logic [3:0] dir;
    } cmd_t;

    // Extended codes carry bit 8 set and therefore never match a direction.
    function automatic logic [3:0] decode_dir(input logic [8:0] code);
        logic [3:0] dir;
        dir = DIR_NONE;
        case (code)
            SC_UP:    dir = DIR_UP;
            SC_DOWN:  dir = DIR_DOWN;
            SC_LEFT:  dir = DIR_LEFT;
            SC_RIGHT: dir = DIR_RIGHT;
            default:  dir = DIR_NONE;
        endcase
        return dir;
    endfunction

    // Priority UP > DOWN > LEFT > RIGHT, i.e. lowest set bit wins.
    function automatic logic [3:0] prio_pick(input logic [3:0] held);
        logic [3:0] dir;
        dir = DIR_NONE;
        if (held[0])      dir = DIR_UP;
        else if (held[1]) dir = DIR_DOWN;
        else if (held[2]) dir = DIR_LEFT;
        else if (held[3]) dir = DIR_RIGHT;
        return dir;
    endfunction

endpackage

// File: rtl/kbd_cmd_fifo.sv
// Synchronous command FIFO; the head is presented from storage with no
// write-to-read bypass, so a push into an empty FIFO shows up next cycle.
module kbd_cmd_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output cmd_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    cmd_t          mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign head = empty ? cmd_t'('0) : mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/kbd_dir_scheduler.sv
// Turns PS/2 make/break events into paced direction commands: fresh command
// per new press, typematic repeats on a delay/period schedule, FIFO-buffered.
module kbd_dir_scheduler
    import kbd_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DELAY_CYC  = 50_000_000,
    parameter int PERIOD_CYC = 10_000_000,
    parameter int CNT_W      = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [8:0] last_change,
    input  logic       key_make,
    output logic       cmd_valid,
    output logic [3:0] cmd_dir,
    output logic       cmd_repeat,
    input  logic       cmd_ready,
    output logic [3:0] held_dir,
    output logic       overflow,
    input  logic       clr_overflow
);

    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(DELAY_CYC);
    localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(PERIOD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       held_q, held_d;
    logic [3:0]       active_q, active_d;
    logic             overflow_q, overflow_d;

    logic [3:0] ev_dir;
    logic       make_new;
    logic       break_held;
    logic       push;
    logic       fresh;
    cmd_t       push_cmd;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    cmd_t       fifo_head;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        held_d   = held_q;
        active_d = active_q;
        push     = 1'b0;
        fresh    = 1'b0;
        push_cmd = '{rpt: 1'b0, dir: DIR_NONE};

        ev_dir     = key_valid ? decode_dir(last_change) : DIR_NONE;
        make_new   = (ev_dir != DIR_NONE) && key_make && ((held_q & ev_dir) == DIR_NONE);
        break_held = (ev_dir != DIR_NONE) && !key_make && ((held_q & ev_dir) != DIR_NONE);

        // Timer runs first; an active-changing key event below overrides it.
        case (state_q)
            IDLE: cnt_d = '0;
            DELAY, REPEAT: begin
                if (cnt_q == CNT_ONE) begin
                    push     = 1'b1;
                    push_cmd = '{rpt: 1'b1, dir: active_q};
                    cnt_d    = PERIOD_LD;
                    state_d  = REPEAT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (make_new) begin
            held_d   = held_q | ev_dir;
            active_d = ev_dir;
            push     = 1'b1;
            fresh    = 1'b1;
            push_cmd = '{rpt: 1'b0, dir: ev_dir};
            cnt_d    = DELAY_LD;
            state_d  = DELAY;
        end else if (break_held) begin
            held_d = held_q & ~ev_dir;
            if (active_q == ev_dir) begin
                push = 1'b0;
                if (held_d != DIR_NONE) begin
                    // Fall back to a still-held key silently; it repeats after a full delay.
                    active_d = prio_pick(held_d);
                    cnt_d    = DELAY_LD;
                    state_d  = DELAY;
                end else begin
                    active_d = DIR_NONE;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (push && fresh && fifo_full && !pop) overflow_d = 1'b1;
        else if (clr_overflow)                  overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            held_q     <= DIR_NONE;
            active_q   <= DIR_NONE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            held_q     <= held_d;
            active_q   <= active_d;
            overflow_q <= overflow_d;
        end
    end

    assign pop = !fifo_empty && cmd_ready;

    kbd_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_cmd),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    assign cmd_valid  = !fifo_empty;
    assign cmd_dir    = fifo_head.dir;
    assign cmd_repeat = fifo_head.rpt;
    assign held_dir   = held_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_kbd_dir_scheduler.sv
// Bench for kbd_dir_scheduler: directed scenarios plus random key traffic,
// checked against a deadline/queue-based behavioural model.
module tb_kbd_dir_scheduler;

    localparam int DEPTH  = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [8:0] last_change;
    logic       key_make;
    logic       cmd_valid;
    logic [3:0] cmd_dir;
    logic       cmd_repeat;
    logic       cmd_ready;
    logic [3:0] held_dir;
    logic       overflow;
    logic       clr_overflow;

    always #5 clk = ~clk;

    kbd_dir_scheduler #(
        .DEPTH     (DEPTH),
        .DELAY_CYC (DELAY),
        .PERIOD_CYC(PERIOD),
        .CNT_W     (27)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .last_change (last_change),
        .key_make    (key_make),
        .cmd_valid   (cmd_valid),
        .cmd_dir     (cmd_dir),
        .cmd_repeat  (cmd_repeat),
        .cmd_ready   (cmd_ready),
        .held_dir    (held_dir),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    logic [10:0] obs;
    assign obs = {cmd_valid, cmd_repeat, cmd_dir, held_dir, overflow};

    int total = 0;
    int bad   = 0;

    // Model: held set, active index, absolute deadline of next repeat, command queue.
    bit         m_held [4];
    int         m_active;
    longint     m_t;
    longint     m_due;
    logic [4:0] m_q [$];
    bit         m_ovf;

    function automatic int code2idx(input logic [8:0] c);
        case (c)
            9'h01D:  return 0;
            9'h01B:  return 1;
            9'h01C:  return 2;
            9'h023:  return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [3:0] h;
        logic [4:0] hd;
        for (int i = 0; i < 4; i++) h[i] = m_held[i];
        hd = (m_q.size() > 0) ? m_q[0] : 5'b0;
        return {m_q.size() > 0, hd, h, m_ovf};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_held[i] = 0;
        m_active = -1;
        m_due    = 0;
        m_q.delete();
        m_ovf    = 0;
    endtask

    // Advance model by one cycle using the current inputs, then clock the DUT.
    task automatic step();
        int         d;
        bit         chg;
        bit         hp;
        bit         fr;
        bit         pp;
        bit         drop;
        logic [4:0] ent;
        chg  = 0; hp = 0; fr = 0; drop = 0; ent = '0;
        pp   = (m_q.size() > 0) && cmd_ready;
        d    = key_valid ? code2idx(last_change) : -1;
        if (d >= 0 && key_make && !m_held[d]) begin
            m_held[d] = 1;
            m_active  = d;
            m_due     = m_t + DELAY;
            hp = 1; fr = 1; chg = 1;
            ent = {1'b0, 4'(1 << d)};
        end else if (d >= 0 && !key_make && m_held[d]) begin
            m_held[d] = 0;
            if (m_active == d) begin
                chg = 1;
                m_active = -1;
                for (int i = 3; i >= 0; i--) if (m_held[i]) m_active = i;
                if (m_active >= 0) m_due = m_t + DELAY;
            end
        end
        if (!chg && m_active >= 0 && m_t == m_due) begin
            hp    = 1;
            ent   = {1'b1, 4'(1 << m_active)};
            m_due = m_t + PERIOD;
        end
        if (pp) void'(m_q.pop_front());
        if (hp) begin
            if (m_q.size() < DEPTH) m_q.push_back(ent);
            else if (fr)            drop = 1;
        end
        if (drop)              m_ovf = 1;
        else if (clr_overflow) m_ovf = 0;
        @(posedge clk);
        #1;
        m_t++;
    endtask

    task automatic key(input logic [8:0] code, input logic make);
        last_change = code;
        key_make    = make;
        key_valid   = 1'b1;
        step();
        key_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs !== 11'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b", obs, 11'b0);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_single_up();
        int reps [$];
        cmd_ready = 1'b1;
        key(9'h01D, 1'b1);
        total++;
        if ({cmd_valid, cmd_repeat, cmd_dir} !== 6'b1_0_0001) begin
            bad++;
            $display("FAIL up_fresh got=%b want=%b", {cmd_valid, cmd_repeat, cmd_dir}, 6'b100001);
        end
        for (int i = 1; i <= 24; i++) begin
            step();
            if (cmd_valid && cmd_repeat && cmd_dir == 4'b0001) reps.push_back(i);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL up_hold cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
        total++;
        if (reps.size() != 4 || reps[0] != 10 || reps[1] != 14 || reps[2] != 18 || reps[3] != 22) begin
            bad++;
            $display("FAIL up_repeat_times got=%p want=10,14,18,22", reps);
        end
        key(9'h01D, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step();
            total++;
            if (obs !== exp_vec() || cmd_valid !== 1'b0 || held_dir !== 4'b0) begin
                bad++;
                $display("FAIL up_released cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_priority();
        int reps [$];
        cmd_ready = 1'b1;
        key(9'h01C, 1'b1);
        total++;
        if ({cmd_valid, cmd_repeat, cmd_dir} !== 6'b1_0_0100) begin
            bad++;
            $display("FAIL left_fresh got=%b want=%b", {cmd_valid, cmd_repeat, cmd_dir}, 6'b100100);
        end
        step(); step();
        key(9'h023, 1'b1);
        total++;
        if ({cmd_valid, cmd_repeat, cmd_dir} !== 6'b1_0_1000) begin
            bad++;
            $display("FAIL right_fresh got=%b want=%b", {cmd_valid, cmd_repeat, cmd_dir}, 6'b101000);
        end
        step(); step();
        key(9'h023, 1'b0);
        total++;
        if (cmd_valid !== 1'b0 || held_dir !== 4'b0100) begin
            bad++;
            $display("FAIL right_break got=%b/%b want=0/0100", cmd_valid, held_dir);
        end
        for (int i = 1; i <= 19; i++) begin
            step();
            if (cmd_valid) reps.push_back(i * 16 + int'(cmd_dir) + (cmd_repeat ? 1000 : 0));
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL left_fallback cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
        total++;
        if (reps.size() != 3 || reps[0] != 1164 || reps[1] != 1228 || reps[2] != 1292) begin
            bad++;
            $display("FAIL fallback_repeats got=%p want=1164,1228,1292", reps);
        end
        key(9'h01C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL left_release cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_ignore();
        key(9'h015, 1'b1);
        key(9'h11D, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step();
            total++;
            if (obs !== exp_vec() || cmd_valid !== 1'b0 || held_dir !== 4'b0) begin
                bad++;
                $display("FAIL ignore_codes cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_overflow();
        logic [8:0] seq [6];
        logic       mk  [6];
        seq = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h01D, 9'h01D};
        mk  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            key(seq[i], mk[i]);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL ovf_fill ev=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
        total++;
        if (overflow !== 1'b1 || {cmd_valid, cmd_repeat, cmd_dir} !== 6'b1_0_0001) begin
            bad++;
            $display("FAIL ovf_set got=%b/%b want=1/100001", overflow, {cmd_valid, cmd_repeat, cmd_dir});
        end
        for (int i = 0; i < 25; i++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL ovf_repeats cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%b want=0", overflow);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            total++;
            if (obs !== exp_vec() || overflow !== 1'b0) begin
                bad++;
                $display("FAIL ovf_repeat_silent cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_full_pop();
        logic [4:0] heads [$];
        key(9'h01B, 1'b0);
        cmd_ready = 1'b1;
        key(9'h01B, 1'b1);
        total++;
        if (overflow !== 1'b0 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL full_pop_push got=%b want=%b", obs, exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            heads.push_back({cmd_repeat, cmd_dir});
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL full_drain cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
        total++;
        if (heads.size() != 4 || heads[0] !== 5'b00010 || heads[1] !== 5'b00100 ||
            heads[2] !== 5'b01000 || heads[3] !== 5'b00010) begin
            bad++;
            $display("FAIL full_order got=%p want=00010,00100,01000,00010", heads);
        end
        key(9'h01D, 1'b0); key(9'h01B, 1'b0); key(9'h01C, 1'b0); key(9'h023, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL full_release cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_mid_reset();
        cmd_ready = 1'b0;
        key(9'h01D, 1'b1);
        for (int i = 1; i <= 11; i++) step();
        total++;
        if (obs !== exp_vec() || cmd_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got=%b want=%b", obs, exp_vec());
        end
        rst = 1'b1;
        #1;
        total++;
        if (obs !== 11'b0) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b", obs, 11'b0);
        end
        model_reset();
        @(posedge clk); @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            total++;
            if (obs !== exp_vec() || cmd_valid !== 1'b0) begin
                bad++;
                $display("FAIL post_reset cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] codes [7];
        codes = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h015, 9'h11D, 9'h11B};
        for (int i = 0; i < 600; i++) begin
            cmd_ready    = ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 19) == 0);
            key_valid    = ($urandom_range(0, 5) == 0);
            last_change  = codes[$urandom_range(0, 6)];
            key_make     = $urandom_range(0, 1) == 1;
            step();
            key_valid    = 1'b0;
            clr_overflow = 1'b0;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        key_valid    = 1'b0;
        last_change  = 9'h0;
        key_make     = 1'b0;
        cmd_ready    = 1'b0;
        clr_overflow = 1'b0;
        m_t          = 0;
        model_reset();
        test_reset();
        test_single_up();
        test_priority();
        test_ignore();
        test_overflow();
        test_full_pop();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kbd_dir_scheduler.md
# kbd_dir_scheduler

Sequences raw key events from the PS/2 keyboard decoder into a paced stream of direction commands for the game logic. Tracks which of the four direction keys are held, picks the active direction (most-recent make wins), issues one command per new press plus typematic repeats on a delay/period schedule, and buffers commands in a small FIFO drained by a valid/ready consumer. Sits between the keyboard decoder and the game state machine, replacing direct combinational use of the decoder's `last_change`.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, 2..16.
- `DELAY_CYC`, 50_000_000: cycles from accepted make to first repeat; must be ≥ 2.
- `PERIOD_CYC`, 10_000_000: cycles between subsequent repeats; must be ≥ 2.
- `CNT_W`, 27: repeat counter width; must hold max(DELAY_CYC, PERIOD_CYC).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `key_valid`  in  1  one-cycle pulse, key event present.
- `last_change`  in  9  {extend, scan code} of the event.
- `key_make`  in  1  1 = press, 0 = release; sampled with `key_valid`.
- `cmd_valid`  out  1  FIFO head valid.
- `cmd_dir`  out  4  one-hot head direction: [0] UP, [1] DOWN, [2] LEFT, [3] RIGHT.
- `cmd_repeat`  out  1  head is a typematic repeat (0 = fresh press).
- `cmd_ready`  in  1  consumer accepts head when high with `cmd_valid`.
- `held_dir`  out  4  currently held direction keys, same bit order.
- `overflow`  out  1  sticky; set when a fresh-press command was dropped on a full FIFO.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Decode: only non-extended codes (`last_change[8]`=0) matter. 0x1D→UP, 0x1B→DOWN, 0x1C→LEFT, 0x23→RIGHT. Any other code, or an extended code, is ignored entirely.
- Make of an unheld direction sets its `held_dir` bit, makes it active, pushes {dir, repeat=0}, and loads the counter with DELAY_CYC (state DELAY).
- Make of an already-held direction has no effect.
- Break clears the `held_dir` bit. If that direction was active:
  - Another direction is still held: the new active direction is the highest-priority held bit (UP > DOWN > LEFT > RIGHT). Nothing is pushed. The counter reloads DELAY_CYC and the FSM enters DELAY.
  - No direction is held: the FSM enters IDLE.
- Break of a non-active direction clears only its held bit.
- FSM states:
  - IDLE: no active direction, counter frozen at 0.
  - DELAY: counter decrements each cycle. At 1 it pushes {active, repeat=1}, reloads PERIOD_CYC, and moves to REPEAT.
  - REPEAT: same countdown, reloading PERIOD_CYC at each push.
- Simultaneous events: a key event in the same cycle as a counter expiry takes precedence. The expiry push is discarded and the counter follows the key-event rule.
- FIFO push and pop:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - A fresh push dropped on full sets `overflow`. A repeat push dropped on full is discarded silently.
  - Pop occurs when `cmd_valid && cmd_ready`.
  - Empty FIFO with a same-cycle push: no bypass; the entry appears next cycle.
  - `clr_overflow` coinciding with a new drop: the set wins.
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally. Full is signalled when the MSBs differ and the remaining bits are equal.

## Timing
- All outputs are registered. Reset values: `cmd_valid`=0, `cmd_dir`=0, `cmd_repeat`=0, `held_dir`=0, `overflow`=0. FSM in IDLE, counter 0, FIFO empty.
- `key_valid` make at cycle k with the FIFO empty: `held_dir` updates and `cmd_valid`=1 at k+1.
- First repeat is pushed at k+DELAY_CYC, visible at k+DELAY_CYC+1. Later repeats follow every PERIOD_CYC cycles.
- `cmd_ready` may be held high continuously; throughput is one command per cycle.
- Holding `cmd_valid` with `cmd_ready` low keeps head data stable.
- Reset asserted mid-operation: everything returns to reset values immediately, and in-flight commands are lost.

## Structure
- Shared package `kbd_pkg` holds:
  - scan-code constants (UP 9'h01D, DOWN 9'h01B, LEFT 9'h01C, RIGHT 9'h023);
  - the one-hot direction encoding;
  - the FSM state enum {IDLE, DELAY, REPEAT}.
- One sub-module, `kbd_cmd_fifo`: synchronous FIFO, DEPTH × 5 bits {repeat, dir[3:0]}, with push/pop/full/empty. The scheduler contains the decode, held set, priority select, FSM and counter.

## Test plan
- Test parameters: DELAY_CYC=10, PERIOD_CYC=4, DEPTH=4.
- Make UP (0x01D), `cmd_ready`=1 → `cmd_valid` pulse with `cmd_dir`=0001, `cmd_repeat`=0 one cycle later. Repeats with `cmd_repeat`=1 follow at +10, +14, +18. Break UP → no further commands, `held_dir`=0.
- Hold LEFT, make RIGHT, then break RIGHT → fresh 0100, fresh 1000, then repeats of 0100 starting 10 cycles after the break; no push at the break itself.
- Make code 0x15, then extended make 0x11D → no command; `held_dir` stays 0.
- `cmd_ready`=0, make UP, DOWN, LEFT, RIGHT, then break and re-make UP → FIFO full with 4 fresh commands, the fifth dropped, `overflow`=1. `clr_overflow` → 0. Repeats meanwhile are dropped without setting `overflow`.
- FIFO full, `cmd_ready`=1 in the same cycle as a fresh make → push accepted, `overflow` stays 0, order preserved.
- Assert `rst` mid-REPEAT with 2 entries queued → all outputs 0 immediately, no command after release until a new make.
